// File: rtl/character_jump_ctrl_pkg.sv
// Shared game package: controller states and default geometry.
// The state machine and drawing blocks pull constants from here.
package character_jump_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AIR_UP,
    ST_AIR_DOWN,
    ST_FALL,
    ST_DEAD
  } jump_state_e;

  localparam int PIX_W         = 11;
  localparam int COLS_D        = 8;
  localparam int COL_W_D       = 64;
  localparam int X_ORG_D       = 64;
  localparam int Y_REST_D      = 400;
  localparam int Y_FLOOR_D     = 600;
  localparam int HALF_FRAMES_D = 8;
  localparam int STEP_D        = 8;

  function automatic logic [PIX_W-1:0] pix(input int v);
    return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/character_jump_ctrl_if.sv
// Game-side bundle for the jump controller.
// master = game state machine, slave = jump controller.
interface character_jump_ctrl_if #(
  parameter int COLS = 8
);
  logic            restart;
  logic            frame_tick;
  logic            jump_left;
  logic            jump_right;
  logic [COLS-1:0] block_map;
  logic [10:0]     char_x;
  logic [10:0]     char_y;
  logic            character_landed;
  logic            jump_fail;
  logic            busy;

  modport master (
    output restart, frame_tick,
    output jump_left, jump_right,
    output block_map,
    input  char_x, char_y,
    input  character_landed,
    input  jump_fail, busy
  );

  modport slave (
    input  restart, frame_tick,
    input  jump_left, jump_right,
    input  block_map,
    output char_x, char_y,
    output character_landed,
    output jump_fail, busy
  );
endinterface

// File: rtl/character_jump_ctrl_step.sv
// Frame-paced half-arc step counter.
// o_term is high while fcnt sits on the last frame of a half arc.
module jump_step_counter #(
  parameter int HALF_FRAMES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);
  localparam logic [3:0] LAST = 4'(HALF_FRAMES - 1);

  logic [3:0] r_fcnt;

  // count ticks, wrap to zero at end of each half arc
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcnt <= '0;
    end else if (i_clr) begin
      r_fcnt <= '0;
    end else if (i_en) begin
      r_fcnt <= o_term ? 4'd0 : r_fcnt + 4'd1;
    end
  end

  assign o_term = (r_fcnt == LAST);
endmodule

// File: rtl/character_jump_ctrl.sv
// Character jump controller: arcs between block columns,
// falls to the floor on a miss, waits in DEAD for restart.
module character_jump_ctrl
  import character_jump_ctrl_pkg::*;
#(
  parameter int COLS        = COLS_D,
  parameter int COL_W       = COL_W_D,
  parameter int X_ORG       = X_ORG_D,
  parameter int Y_REST      = Y_REST_D,
  parameter int Y_FLOOR     = Y_FLOOR_D,
  parameter int HALF_FRAMES = HALF_FRAMES_D,
  parameter int STEP        = STEP_D
) (
  input  logic                 clk,
  input  logic                 rst,
  character_jump_ctrl_if.slave bus
);
  localparam int COL_BW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int TGT_W  = COL_BW + 2;

  localparam logic [10:0] P_XORG  = pix(X_ORG);
  localparam logic [10:0] P_YREST = pix(Y_REST);
  localparam logic [10:0] P_YFLR  = pix(Y_FLOOR);
  localparam logic [10:0] P_STEP  = pix(STEP);
  localparam logic [10:0] P_XSTEP =
    pix(COL_W / (2 * HALF_FRAMES));
  localparam logic [TGT_W-1:0] LAST_COL =
    TGT_W'(COLS - 1);

  jump_state_e       r_state, w_nxt;
  logic [COL_BW-1:0] r_col, w_col;
  logic signed [1:0] r_dir, w_dir;
  logic [10:0]       r_x, w_x;
  logic [10:0]       r_y, w_y;
  logic              r_land, w_land;
  logic              r_fail, w_fail;

  logic              w_clr;
  logic              w_cnt_en;
  logic              w_term;
  logic [TGT_W-1:0]  w_tgt;
  logic              w_tgt_ok;
  logic [10:0]       w_step_x;
  logic [10:0]       w_fall_y;

  jump_step_counter #(
    .HALF_FRAMES (HALF_FRAMES)
  ) u_step (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (w_cnt_en),
    .o_term (w_term)
  );

  // landing target and per-frame pixel steps
  always_comb begin
    w_tgt = {2'b00, r_col}
          + {{COL_BW{r_dir[1]}}, r_dir};
    w_tgt_ok = !w_tgt[TGT_W-1]
             && (w_tgt <= LAST_COL)
             && bus.block_map[w_tgt[COL_BW-1:0]];
    w_step_x = r_dir[1] ? (r_x - P_XSTEP)
                        : (r_x + P_XSTEP);
    w_fall_y = r_y + P_STEP;
  end

  // next-state and next-output decode
  always_comb begin
    w_nxt    = r_state;
    w_col    = r_col;
    w_dir    = r_dir;
    w_x      = r_x;
    w_y      = r_y;
    w_land   = 1'b0;
    w_fail   = r_fail;
    w_clr    = 1'b0;
    w_cnt_en = 1'b0;
    if (bus.restart) begin
      w_nxt  = ST_IDLE;
      w_col  = '0;
      w_x    = P_XORG;
      w_y    = P_YREST;
      w_fail = 1'b0;
      w_clr  = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.jump_left) begin
            w_dir = -2'sd1;
            w_clr = 1'b1;
            w_nxt = ST_AIR_UP;
          end else if (bus.jump_right) begin
            w_dir = 2'sd1;
            w_clr = 1'b1;
            w_nxt = ST_AIR_UP;
          end
        end
        ST_AIR_UP: begin
          if (bus.frame_tick) begin
            w_cnt_en = 1'b1;
            w_x      = w_step_x;
            w_y      = r_y - P_STEP;
            if (w_term) w_nxt = ST_AIR_DOWN;
          end
        end
        ST_AIR_DOWN: begin
          if (bus.frame_tick) begin
            w_cnt_en = 1'b1;
            w_x      = w_step_x;
            w_y      = w_fall_y;
            if (w_term) begin
              w_land = 1'b1;
              if (w_tgt_ok) begin
                w_col = w_tgt[COL_BW-1:0];
                w_nxt = ST_IDLE;
              end else begin
                w_fail = 1'b1;
                w_nxt  = ST_FALL;
              end
            end
          end
        end
        ST_FALL: begin
          if (bus.frame_tick) begin
            if (w_fall_y >= P_YFLR) begin
              w_y    = P_YFLR;
              w_land = 1'b1;
              w_nxt  = ST_DEAD;
            end else begin
              w_y = w_fall_y;
            end
          end
        end
        ST_DEAD: begin
          w_nxt = ST_DEAD;
        end
        default: begin
          w_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_col   <= '0;
      r_dir   <= 2'sd1;
      r_x     <= P_XORG;
      r_y     <= P_YREST;
      r_land  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_col   <= w_col;
      r_dir   <= w_dir;
      r_x     <= w_x;
      r_y     <= w_y;
      r_land  <= w_land;
      r_fail  <= w_fail;
    end
  end

  assign bus.char_x           = r_x;
  assign bus.char_y           = r_y;
  assign bus.character_landed = r_land;
  assign bus.jump_fail        = r_fail;
  assign bus.busy = (r_state == ST_AIR_UP)
                 || (r_state == ST_AIR_DOWN)
                 || (r_state == ST_FALL);
endmodule

// File: tb/tb_character_jump_ctrl.sv
// Directed bench for character_jump_ctrl.
// Each task drives one scenario and checks inline.
module tb_character_jump_ctrl;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   lands;

  character_jump_ctrl_if #(.COLS(8)) bus ();

  character_jump_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.character_landed === 1'b1) lands++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      cyc();
      bus.frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    cyc();
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.restart = 1'b0;
    bus.frame_tick = 1'b0;
    bus.jump_left = 1'b0;
    bus.jump_right = 1'b0;
    bus.block_map = 8'h00;
    repeat (3) cyc();
    total++;
    if (bus.char_x !== 11'd64) begin
      bad++;
      $display("FAIL rst_x got=%0d exp=64", bus.char_x);
    end
    total++;
    if (bus.char_y !== 11'd400) begin
      bad++;
      $display("FAIL rst_y got=%0d exp=400", bus.char_y);
    end
    total++;
    if ({bus.character_landed, bus.jump_fail, bus.busy}
        !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=000",
        {bus.character_landed, bus.jump_fail, bus.busy});
    end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_jump_right();
    int l0;
    l0 = lands;
    bus.block_map = 8'b0000_0010;
    bus.jump_right = 1'b1;
    cyc();
    bus.jump_right = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL jr_busy got=%b exp=1", bus.busy);
    end
    tick(8);
    total++;
    if (bus.char_x !== 11'd96 || bus.char_y !== 11'd336) begin
      bad++;
      $display("FAIL jr_apex got=%0d,%0d exp=96,336",
        bus.char_x, bus.char_y);
    end
    tick(7);
    bus.frame_tick = 1'b1;
    cyc();
    bus.frame_tick = 1'b0;
    total++;
    if (bus.character_landed !== 1'b1) begin
      bad++;
      $display("FAIL jr_pulse got=%b exp=1",
        bus.character_landed);
    end
    cyc();
    total++;
    if (bus.character_landed !== 1'b0) begin
      bad++;
      $display("FAIL jr_pulse_end got=%b exp=0",
        bus.character_landed);
    end
    total++;
    if (bus.char_x !== 11'd128 || bus.char_y !== 11'd400) begin
      bad++;
      $display("FAIL jr_pos got=%0d,%0d exp=128,400",
        bus.char_x, bus.char_y);
    end
    total++;
    if ({bus.jump_fail, bus.busy} !== 2'b00
        || lands - l0 !== 1) begin
      bad++;
      $display("FAIL jr_end fail/busy=%b lands=%0d exp=00/1",
        {bus.jump_fail, bus.busy}, lands - l0);
    end
  endtask

  task automatic test_left_off_grid();
    int l0;
    do_restart();
    l0 = lands;
    total++;
    if (bus.char_x !== 11'd64 || lands != l0) begin
      bad++;
      $display("FAIL rs_x got=%0d lands=%0d exp=64/0",
        bus.char_x, lands - l0);
    end
    bus.block_map = 8'hFF;
    bus.jump_left = 1'b1;
    cyc();
    bus.jump_left = 1'b0;
    tick(16);
    total++;
    if (bus.jump_fail !== 1'b1 || bus.busy !== 1'b1
        || lands - l0 !== 1) begin
      bad++;
      $display("FAIL lg_miss fail=%b busy=%b lands=%0d exp=1,1,1",
        bus.jump_fail, bus.busy, lands - l0);
    end
    total++;
    if (bus.char_x !== 11'd0 || bus.char_y !== 11'd400) begin
      bad++;
      $display("FAIL lg_pos got=%0d,%0d exp=0,400",
        bus.char_x, bus.char_y);
    end
    tick(1);
    total++;
    if (bus.char_y !== 11'd408 || bus.char_x !== 11'd0) begin
      bad++;
      $display("FAIL lg_fall1 got=%0d,%0d exp=0,408",
        bus.char_x, bus.char_y);
    end
    tick(23);
    total++;
    if (bus.char_y !== 11'd592 || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL lg_fall24 y=%0d busy=%b exp=592,1",
        bus.char_y, bus.busy);
    end
    tick(1);
    total++;
    if (bus.char_y !== 11'd600 || bus.busy !== 1'b0
        || lands - l0 !== 2) begin
      bad++;
      $display("FAIL lg_dead y=%0d busy=%b lands=%0d exp=600,0,2",
        bus.char_y, bus.busy, lands - l0);
    end
    bus.jump_right = 1'b1;
    cyc();
    bus.jump_right = 1'b0;
    tick(3);
    total++;
    if (bus.busy !== 1'b0 || bus.char_x !== 11'd0
        || bus.char_y !== 11'd600) begin
      bad++;
      $display("FAIL lg_dead_hold busy=%b pos=%0d,%0d exp=0,0,600",
        bus.busy, bus.char_x, bus.char_y);
    end
    do_restart();
    total++;
    if (bus.jump_fail !== 1'b0 || bus.char_x !== 11'd64
        || bus.char_y !== 11'd400 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL lg_restart fail=%b pos=%0d,%0d exp=0,64,400",
        bus.jump_fail, bus.char_x, bus.char_y);
    end
    cyc();
    total++;
    if (lands - l0 !== 2) begin
      bad++;
      $display("FAIL lg_restart_pulse lands=%0d exp=2",
        lands - l0);
    end
  endtask

  task automatic test_miss_right();
    int l0;
    l0 = lands;
    bus.block_map = 8'h00;
    bus.jump_right = 1'b1;
    cyc();
    bus.jump_right = 1'b0;
    tick(16);
    total++;
    if (bus.jump_fail !== 1'b1 || bus.char_x !== 11'd128
        || lands - l0 !== 1) begin
      bad++;
      $display("FAIL mr_miss fail=%b x=%0d lands=%0d exp=1,128,1",
        bus.jump_fail, bus.char_x, lands - l0);
    end
    tick(25);
    total++;
    if (bus.char_y !== 11'd600 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL mr_floor y=%0d busy=%b exp=600,0",
        bus.char_y, bus.busy);
    end
    bus.jump_left = 1'b1;
    cyc();
    cyc();
    bus.jump_left = 1'b0;
    tick(2);
    total++;
    if (bus.busy !== 1'b0 || bus.char_x !== 11'd128
        || lands - l0 !== 2) begin
      bad++;
      $display("FAIL mr_dead busy=%b x=%0d lands=%0d exp=0,128,2",
        bus.busy, bus.char_x, lands - l0);
    end
    do_restart();
  endtask

  task automatic test_both_held();
    bus.block_map = 8'hFF;
    repeat (3) begin
      bus.jump_right = 1'b1;
      cyc();
      bus.jump_right = 1'b0;
      tick(16);
    end
    total++;
    if (bus.char_x !== 11'd256 || bus.jump_fail !== 1'b0) begin
      bad++;
      $display("FAIL bh_col3 x=%0d fail=%b exp=256,0",
        bus.char_x, bus.jump_fail);
    end
    bus.block_map = 8'h00;
    bus.jump_left = 1'b1;
    bus.jump_right = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.jump_left = 1'b0;
    bus.jump_right = 1'b0;
    tick(15);
    bus.block_map = 8'b0000_0100;
    tick(1);
    total++;
    if (bus.char_x !== 11'd192 || bus.jump_fail !== 1'b0
        || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL bh_left x=%0d fail=%b busy=%b exp=192,0,0",
        bus.char_x, bus.jump_fail, bus.busy);
    end
  endtask

  task automatic test_reset_mid_air();
    int l0;
    l0 = lands;
    bus.block_map = 8'hFF;
    bus.jump_right = 1'b1;
    cyc();
    bus.jump_right = 1'b0;
    tick(5);
    total++;
    if (bus.char_x !== 11'd212 || bus.char_y !== 11'd360) begin
      bad++;
      $display("FAIL ra_pre got=%0d,%0d exp=212,360",
        bus.char_x, bus.char_y);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (bus.char_x !== 11'd64 || bus.char_y !== 11'd400
        || bus.busy !== 1'b0 || bus.character_landed !== 1'b0) begin
      bad++;
      $display("FAIL ra_reset pos=%0d,%0d busy=%b exp=64,400,0",
        bus.char_x, bus.char_y, bus.busy);
    end
    cyc();
    rst = 1'b1;
    tick(20);
    total++;
    if (lands != l0 || bus.busy !== 1'b0
        || bus.char_x !== 11'd64) begin
      bad++;
      $display("FAIL ra_after lands=%0d x=%0d exp=0,64",
        lands - l0, bus.char_x);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    lands = 0;
    test_reset();
    test_jump_right();
    test_left_off_grid();
    test_miss_right();
    test_both_held();
    test_reset_mid_air();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/character_jump_ctrl.md
CHARACTER_JUMP_CTRL -- requirements
Module: character_jump_ctrl

Interface
REQ-001 Parameters (name, default, meaning): COLS 8, number of block columns; COL_W 64, column pitch in pixels; X_ORG 64, pixel x of column 0; Y_REST 400, pixel y of character standing on a block; Y_FLOOR 600, pixel y where a fall ends; HALF_FRAMES 8, frames per jump half-arc; STEP 8, pixels per frame for the jump and the fall.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-low.
REQ-004 restart  in  1  synchronous, one cycle: return the character to its start position and clear the fail flag.
REQ-005 frame_tick  in  1  one-cycle pulse per video frame; paces all motion.
REQ-006 jump_left / jump_right  in  1 each  jump request from the game state machine; held for at least one cycle.
REQ-007 block_map  in  COLS  bit i = 1 when a block is present under column i.
REQ-008 char_x  out  11  character pixel x, registered.
REQ-009 char_y  out  11  character pixel y, registered.
REQ-010 character_landed  out  1  one-cycle pulse when a jump or a fall ends.
REQ-011 jump_fail  out  1  level; set when a landing misses a block or leaves the grid.
REQ-012 busy  out  1  high in AIR and FALL.

Function
REQ-013 The block SHALL use the states IDLE, AIR_UP, AIR_DOWN, FALL and DEAD, with a 3-bit column register col, a signed direction register dir (-1/+1) and a 4-bit frame counter fcnt.
REQ-014 In IDLE: jump_left SHALL set dir=-1, clear fcnt and enter AIR_UP on the next edge; jump_right SHALL set dir=+1; if both are high, jump_left SHALL win.
REQ-015 In AIR_UP, on each frame_tick: char_y -= STEP, char_x += dir*COL_W/(2*HALF_FRAMES) and fcnt++; after HALF_FRAMES ticks the block SHALL enter AIR_DOWN with fcnt cleared.
REQ-016 AIR_DOWN SHALL apply the same x step with char_y += STEP; after HALF_FRAMES ticks char_y equals Y_REST and the block SHALL evaluate the landing in that same cycle.
REQ-017 Landing: the target is col+dir; if the target is in 0..COLS-1 and block_map[target]=1, the block SHALL set col=target, pulse character_landed and return to IDLE.
REQ-018 If the target is outside the grid (col 0 going left, or col COLS-1 going right), or the block bit is 0, the block SHALL pulse character_landed, set jump_fail and enter FALL; col is not updated.
REQ-019 In FALL, each frame_tick SHALL give char_y += STEP with char_x held; when char_y >= Y_FLOOR, char_y SHALL saturate at Y_FLOOR, character_landed SHALL pulse, and the block SHALL enter DEAD.
REQ-020 DEAD SHALL hold all outputs and ignore jump requests until restart.
REQ-021 Jump requests in any state other than IDLE SHALL be ignored and not queued.
REQ-022 restart SHALL override everything in any state: col=0, char_x=X_ORG, char_y=Y_REST, jump_fail=0, state IDLE, with no character_landed pulse.
REQ-023 block_map SHALL be sampled only in the landing cycle; changes during flight have no effect.
REQ-024 Pixel arithmetic SHALL be unsigned 11-bit; char_x stays in X_ORG..X_ORG+(COLS-1)*COL_W for in-grid jumps and may overshoot by one COL_W for off-grid jumps, with no wrap.

Reset
REQ-025 While rst=0: state IDLE, col=0, dir=+1, fcnt=0, char_x=X_ORG, char_y=Y_REST, character_landed=0, jump_fail=0, busy=0.
REQ-026 Assertion of rst mid-flight or mid-fall SHALL abort the motion immediately, without a landed pulse.

Structure
REQ-027 State encodings and the default geometry constants (COL_W, X_ORG, Y_REST, Y_FLOOR, STEP) SHALL live in the shared game package; state_machine.v and the drawing blocks SHALL reference the same constants.
REQ-028 The frame-paced step generator (fcnt plus the half-arc terminal flag) SHALL be one sub-module, jump_step_counter; everything else stays flat.

Verification
REQ-029 Reset, then jump_right with block_map=8'b0000_0010 and 16 frame_ticks -> char_x=X_ORG+64, char_y=Y_REST, one landed pulse, jump_fail=0.
REQ-030 From col 0, jump_left -> after 16 ticks: landed pulse, jump_fail=1, FALL; char_y rises by 8 per tick to 600, then a second landed pulse and DEAD.
REQ-031 jump_right with block_map=8'b0000_0000 -> miss at tick 16, jump_fail=1, fall to Y_FLOOR, jump requests ignored in DEAD.
REQ-032 jump_left and jump_right in the same cycle from col 3 with block_map[2]=1 -> lands at col 2.
REQ-033 rst asserted at tick 5 of AIR_UP -> outputs at reset values at once, no landed pulse; restart in DEAD -> IDLE at col 0 and jump_fail=0 in the next cycle.
